// File: rtl/npc_btb_unit.sv
// F-stage next-PC generator: architectural PC plus a direct-mapped BTB with 2-bit counters.
// Lookup is combinational on pc; resolution, redirects and BTB writes take effect on the clock edge.
module npc_btb_unit #(
    parameter int               WIDTH     = 32,
    parameter int               BTB_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_PC    = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_pc,
    input  logic             res_is_cf,
    input  logic             res_is_uncond,
    input  logic             res_taken,
    input  logic [WIDTH-1:0] res_target,
    input  logic             res_pred_taken,
    input  logic [WIDTH-1:0] res_pred_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic             flush,
    output logic [15:0]      mispred_cnt
);
    localparam int IDXW = $clog2(BTB_DEPTH);
    localparam int TAGW = WIDTH - IDXW - 2;

    logic [WIDTH-1:0] r_pc;
    logic [15:0]      r_cnt;
    logic             r_valid  [BTB_DEPTH];
    logic [TAGW-1:0]  r_tag    [BTB_DEPTH];
    logic [WIDTH-1:0] r_target [BTB_DEPTH];
    logic [1:0]       r_ctr    [BTB_DEPTH];

    logic [IDXW-1:0]  w_idx;
    logic [TAGW-1:0]  w_tag;
    logic             w_hit;
    logic [WIDTH-1:0] w_pc4;
    logic [IDXW-1:0]  w_ridx;
    logic [TAGW-1:0]  w_rtag;
    logic             w_rhit;
    logic [WIDTH-1:0] w_res_tgt;
    logic [WIDTH-1:0] w_epc;
    logic [WIDTH-1:0] w_res_pc4;
    logic [WIDTH-1:0] w_fix_pc;
    logic             w_cf_wrong;
    logic             w_mp;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_unused;

    assign w_unused = &{1'b0, res_target[1:0], epc[1:0]};

    assign w_idx       = r_pc[IDXW+1:2];
    assign w_tag       = r_pc[WIDTH-1:IDXW+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pc4       = r_pc + WIDTH'(4);
    assign pred_taken  = w_hit && r_ctr[w_idx][1];
    assign pred_target = pred_taken ? r_target[w_idx] : w_pc4;

    assign w_ridx    = res_pc[IDXW+1:2];
    assign w_rtag    = res_pc[WIDTH-1:IDXW+2];
    assign w_rhit    = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
    assign w_res_tgt = {res_target[WIDTH-1:2], 2'b00};
    assign w_epc     = {epc[WIDTH-1:2], 2'b00};
    assign w_res_pc4 = res_pc + WIDTH'(4);

    // A non-branch that was predicted taken came from an aliased entry: fall through.
    assign w_cf_wrong = (res_taken != res_pred_taken) ||
                        (res_taken && (w_res_tgt != res_pred_target));
    assign w_mp       = res_valid && (res_is_cf ? w_cf_wrong : res_pred_taken);
    assign w_fix_pc   = (res_is_cf && res_taken) ? w_res_tgt : w_res_pc4;

    assign flush       = w_mp;
    assign pc          = r_pc;
    assign mispred_cnt = r_cnt;

    always_comb begin
        w_next_pc = pred_target;
        if (exc_req)       w_next_pc = EXC_PC;
        else if (eret_req) w_next_pc = w_epc;
        else if (w_mp)     w_next_pc = w_fix_pc;
        else if (stall)    w_next_pc = r_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_cnt <= 16'h0000;
        end else begin
            r_pc <= w_next_pc;
            if (w_mp && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'h0001;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b00;
            end
        end else if (res_valid) begin
            if (res_is_cf) begin
                if (w_rhit) begin
                    if (res_is_uncond)
                        r_ctr[w_ridx] <= 2'b11;
                    else if (res_taken)
                        r_ctr[w_ridx] <= (r_ctr[w_ridx] == 2'b11) ? 2'b11 : r_ctr[w_ridx] + 2'b01;
                    else
                        r_ctr[w_ridx] <= (r_ctr[w_ridx] == 2'b00) ? 2'b00 : r_ctr[w_ridx] - 2'b01;
                    if (res_taken) r_target[w_ridx] <= w_res_tgt;
                end else if (res_taken) begin
                    r_valid[w_ridx]  <= 1'b1;
                    r_tag[w_ridx]    <= w_rtag;
                    r_target[w_ridx] <= w_res_tgt;
                    r_ctr[w_ridx]    <= res_is_uncond ? 2'b11 : 2'b10;
                end
            end else if (w_rhit) begin
                r_valid[w_ridx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_npc_btb_unit.sv
// Bench for npc_btb_unit: directed scenarios then random traffic against an array-based BTB model.
module tb_npc_btb_unit;
    localparam int          D   = 16;
    localparam logic [31:0] RST = 32'h0000_3000;
    localparam logic [31:0] EXC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset, stall, res_valid, res_is_cf, res_is_uncond, res_taken, res_pred_taken;
    logic        exc_req, eret_req;
    logic [31:0] res_pc, res_target, res_pred_target, epc;
    logic [31:0] pc, pred_target;
    logic        pred_taken, flush;
    logic [15:0] mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    bit          m_v   [D];
    logic [31:0] m_tag [D];
    logic [31:0] m_tgt [D];
    int          m_ctr [D];

    npc_btb_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_cf(res_is_cf),
        .res_is_uncond(res_is_uncond), .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .flush(flush), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic int f_idx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(D));
    endfunction

    function automatic logic [31:0] f_tag(input logic [31:0] a);
        return a / 32'(4 * D);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_v[f_idx(a)] && (m_tag[f_idx(a)] == f_tag(a));
    endfunction

    function automatic bit m_ptk(input logic [31:0] a);
        return m_hit(a) && (m_ctr[f_idx(a)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] a);
        return m_ptk(a) ? m_tgt[f_idx(a)] : a + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc  = RST;
        m_cnt = 16'h0;
        for (int i = 0; i < D; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        stall = 0; res_valid = 0; res_pc = 0; res_is_cf = 0; res_is_uncond = 0;
        res_taken = 0; res_target = 0; res_pred_taken = 0; res_pred_target = 0;
        exc_req = 0; eret_req = 0; epc = 0;
    endtask

    // Entered at posedge+1: drive, check combinational outputs, clock, check registered state.
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input bit cf,
                        input bit unc, input bit tk, input logic [31:0] tgt, input bit ptk,
                        input logic [31:0] ptgt, input bit exc, input bit eret,
                        input logic [31:0] e);
        bit          mp;
        int          i;
        logic [31:0] tm, em, nxt;
        stall = st; res_valid = rv; res_pc = rpc; res_is_cf = cf; res_is_uncond = unc;
        res_taken = tk; res_target = tgt; res_pred_taken = ptk; res_pred_target = ptgt;
        exc_req = exc; eret_req = eret; epc = e;
        #3;
        tm = {tgt[31:2], 2'b00};
        em = {e[31:2], 2'b00};
        mp = rv && (cf ? ((tk != ptk) || (tk && tm != ptgt)) : ptk);
        if (exc)       nxt = EXC;
        else if (eret) nxt = em;
        else if (mp)   nxt = (cf && tk) ? tm : rpc + 32'd4;
        else if (st)   nxt = m_pc;
        else           nxt = m_ptgt(m_pc);
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, m_ptk(m_pc)});
        chk("pred_target", pred_target, m_ptgt(m_pc));
        chk("flush", {31'b0, flush}, {31'b0, mp});
        @(posedge clk);
        #1;
        i = f_idx(rpc);
        if (rv && cf) begin
            if (m_hit(rpc)) begin
                if (unc)     m_ctr[i] = 3;
                else if (tk) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else         m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                if (tk) m_tgt[i] = tm;
            end else if (tk) begin
                m_v[i] = 1'b1; m_tag[i] = f_tag(rpc); m_tgt[i] = tm; m_ctr[i] = unc ? 3 : 2;
            end
        end else if (rv && m_hit(rpc)) begin
            m_v[i] = 1'b0;
        end
        if (mp && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
        m_pc = nxt;
        chk("pc", pc, m_pc);
        chk("mispred_cnt", {16'b0, mispred_cnt}, {16'b0, m_cnt});
        drive_idle();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go_eret(input logic [31:0] a);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a);
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        model_reset();
        #2;
        chk("rst_pc", pc, RST);
        chk("rst_pred", {31'b0, pred_taken}, 32'd0);
        chk("rst_cnt", {16'b0, mispred_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // sequential fetch
        idle();
        idle();
        chk("t1_pc3008", pc, 32'h3008);
        idle();
        idle();

        // first taken resolution allocates and redirects
        chk("t2_at3010", pc, 32'h3010);
        step(0, 1, 32'h3010, 1, 0, 1, 32'h3040, 0, 32'h3014, 0, 0, 0);
        chk("t2_pc", pc, 32'h3040);
        go_eret(32'h3010);
        chk("t2_pred", {31'b0, pred_taken}, 32'd1);
        chk("t2_ptgt", pred_target, 32'h3040);

        // strengthen to 11, then two not-taken resolutions
        step(0, 1, 32'h3010, 1, 0, 1, 32'h3040, 1, 32'h3040, 0, 0, 0);
        go_eret(32'h3010);
        step(0, 1, 32'h3010, 1, 0, 0, 32'h3040, 1, 32'h3040, 0, 0, 0);
        chk("t3_redirect", pc, 32'h3014);
        go_eret(32'h3010);
        chk("t3_pred_a", {31'b0, pred_taken}, 32'd1);
        step(0, 1, 32'h3010, 1, 0, 0, 32'h3040, 1, 32'h3040, 0, 0, 0);
        go_eret(32'h3010);
        chk("t3_pred_b", {31'b0, pred_taken}, 32'd0);

        // exception beats mispredict and stall; BTB and counter still update
        step(1, 1, 32'h3010, 1, 0, 1, 32'h3040, 0, 32'h3014, 1, 0, 0);
        chk("t4_pc", pc, EXC);
        chk("t4_cnt", {16'b0, mispred_cnt}, 32'd4);
        go_eret(32'h3010);
        chk("t4_btb", {31'b0, pred_taken}, 32'd1);

        // alias replaces the entry for 3010
        step(0, 1, 32'h3010 + 32'(D * 4), 1, 0, 1, 32'h3100, 0, 32'h3054, 0, 0, 0);
        go_eret(32'h3010);
        chk("t5_evicted", {31'b0, pred_taken}, 32'd0);
        go_eret(32'h3010 + 32'(D * 4));
        chk("t5_alias_pred", {31'b0, pred_taken}, 32'd1);
        chk("t5_alias_tgt", pred_target, 32'h3100);

        // wrap at top of address space
        go_eret(32'hFFFF_FFFC);
        idle();
        chk("t6_wrap", pc, 32'h0000_0000);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] rpc, tgt, ptgt, e;
            bit          rv, cf, unc, tk, ptk;
            rpc = 32'h3000 + 32'd4 * $urandom_range(0, 31);
            cf  = ($urandom_range(0, 4) != 0);
            unc = cf && ($urandom_range(0, 3) == 0);
            tk  = cf && (unc || ($urandom_range(0, 1) == 1));
            tgt = 32'h3000 + 32'd4 * $urandom_range(0, 63) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                ptk = m_ptk(rpc); ptgt = m_ptgt(rpc);
            end else begin
                ptk = ($urandom_range(0, 1) == 1); ptgt = 32'h3000 + 32'd4 * $urandom_range(0, 63);
            end
            rv = ($urandom_range(0, 2) != 0);
            e  = 32'h3000 + 32'd4 * $urandom_range(0, 31) + 32'($urandom_range(0, 3));
            step(($urandom_range(0, 3) == 0), rv, rpc, cf, unc, tk, tgt, ptk, ptgt,
                 ($urandom_range(0, 30) == 0), ($urandom_range(0, 20) == 0), e);
        end

        // asynchronous reset in the middle of a cycle
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc, RST);
        chk("mid_rst_pred", {31'b0, pred_taken}, 32'd0);
        chk("mid_rst_cnt", {16'b0, mispred_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 8; n++) begin
            chk("post_rst_pred", {31'b0, pred_taken}, 32'd0);
            idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
